// File: rtl/block_stats_if.sv
// Sample-in / block-result-out bundle for block_stats.
// The slave side is the statistics block; the master side feeds samples and consumes results.
interface block_stats_if #(
  parameter int W      = 16,
  parameter int N_LOG2 = 3
);
  logic                       in_valid;
  logic signed [W-1:0]        X;
  logic                       out_ready;
  logic                       out_valid;
  logic signed [W+N_LOG2-1:0] sum;
  logic signed [W-1:0]        mean;
  logic signed [W-1:0]        min;
  logic signed [W-1:0]        max;
  logic                       overrun;

  modport master (
    output in_valid, X, out_ready,
    input  out_valid, sum, mean, min, max, overrun
  );

  modport slave (
    input  in_valid, X, out_ready,
    output out_valid, sum, mean, min, max, overrun
  );
endinterface

// File: rtl/block_stats.sv
// Block statistics: sum/mean/min/max over blocks of 2**N_LOG2 valid samples,
// presented through a one-entry valid/ready result register with a sticky overrun flag.
module block_stats #(
  parameter int W      = 16,
  parameter int N_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  block_stats_if.slave  bus
);
  localparam int AW = W + N_LOG2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [N_LOG2-1:0]     cnt;
  logic signed [AW-1:0]  acc, x_ext, fin_sum, sum_r;
  logic signed [W-1:0]   run_min, run_max, fin_min, fin_max, min_r, max_r;
  logic                  last, complete, load, ovr_set, ovr_r;

  assign x_ext    = {{N_LOG2{bus.X[W-1]}}, bus.X};
  assign last     = (cnt == '1);
  assign complete = bus.in_valid && last;

  // Final values fold in the current sample so completion needs no extra cycle.
  assign fin_sum = acc + x_ext;
  assign fin_min = (bus.X < run_min) ? bus.X : run_min;
  assign fin_max = (bus.X > run_max) ? bus.X : run_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      run_min <= '0;
      run_max <= '0;
    end else if (bus.in_valid) begin
      cnt <= cnt + 1'b1;
      if (cnt == '0) begin
        acc     <= x_ext;
        run_min <= bus.X;
        run_max <= bus.X;
      end else begin
        acc     <= fin_sum;
        run_min <= fin_min;
        run_max <= fin_max;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          if (bus.out_ready) load    = 1'b1;
          else               ovr_set = 1'b1;
        end else if (bus.out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= '0;
      min_r <= '0;
      max_r <= '0;
      ovr_r <= 1'b0;
    end else begin
      if (load) begin
        sum_r <= fin_sum;
        min_r <= fin_min;
        max_r <= fin_max;
      end
      if (ovr_set) ovr_r <= 1'b1;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.sum       = sum_r;
  assign bus.mean      = W'(sum_r >>> N_LOG2);
  assign bus.min       = min_r;
  assign bus.max       = max_r;
  assign bus.overrun   = ovr_r;
endmodule

// File: tb/tb_block_stats.sv
// Self-checking bench for block_stats: block-vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_block_stats;
  localparam int W      = 16;
  localparam int N_LOG2 = 3;
  localparam int N      = 1 << N_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_stats_if #(.W(W), .N_LOG2(N_LOG2)) bus ();
  block_stats #(.W(W), .N_LOG2(N_LOG2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open block plus the result register contents.
  int q[$];
  bit m_valid;
  int m_sum, m_mean, m_min, m_max;
  bit m_ovr;

  typedef struct {
    int xs[8];
    int sum;
    int mean;
    int mn;
    int mx;
  } vec_t;
  vec_t tbl[6];

  function automatic int floor_div(int s, int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_sum = 0; m_mean = 0; m_min = 0; m_max = 0; m_ovr = 0;
  endtask

  task automatic model_step(bit v, int x, bit rdy);
    bit done = 0;
    int s, mn, mx;
    if (v) begin
      q.push_back(x);
      if (q.size() == N) begin
        s = 0; mn = q[0]; mx = q[0];
        foreach (q[i]) begin
          s += q[i];
          if (q[i] < mn) mn = q[i];
          if (q[i] > mx) mx = q[i];
        end
        q.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid = 1; m_sum = s; m_mean = floor_div(s, N); m_min = mn; m_max = mx;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".out_valid"}, int'(bus.out_valid), int'(m_valid));
    chk({tag, ".sum"},       int'(bus.sum),       m_sum);
    chk({tag, ".mean"},      int'(bus.mean),      m_mean);
    chk({tag, ".min"},       int'(bus.min),       m_min);
    chk({tag, ".max"},       int'(bus.max),       m_max);
    chk({tag, ".overrun"},   int'(bus.overrun),   int'(m_ovr));
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check on the next falling edge.
  task automatic cycle(bit v, int x, bit rdy);
    bus.in_valid  = v;
    bus.X         = W'(x);
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(v, x, rdy);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.X = '0; bus.out_ready = 0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("rst_release");
  endtask

  task automatic send_block(int xs[8], bit rdy);
    for (int i = 0; i < N; i++) cycle(1'b1, xs[i], rdy);
  endtask

  initial begin
    bus.in_valid = 0; bus.X = '0; bus.out_ready = 0;
    model_reset();

    tbl[0].xs = '{1, 2, 3, 4, 5, 6, 7, 8};                         tbl[0].sum = 36;      tbl[0].mean = 4;      tbl[0].mn = 1;      tbl[0].mx = 8;
    tbl[1].xs = '{-1, -1, -1, -1, -1, -1, -1, -2};                 tbl[1].sum = -9;      tbl[1].mean = -2;     tbl[1].mn = -2;     tbl[1].mx = -1;
    tbl[2].xs = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    tbl[2].sum = 262136;  tbl[2].mean = 32767;  tbl[2].mn = 32767;  tbl[2].mx = 32767;
    tbl[3].xs = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    tbl[3].sum = -262144; tbl[3].mean = -32768; tbl[3].mn = -32768; tbl[3].mx = -32768;
    tbl[4].xs = '{5, -3, 0, 7, -8, 2, 1, -4};                      tbl[4].sum = 0;       tbl[4].mean = 0;      tbl[4].mn = -8;     tbl[4].mx = 7;
    tbl[5].xs = '{-3, 0, 0, 0, 0, 0, 0, 0};                        tbl[5].sum = -3;      tbl[5].mean = -1;     tbl[5].mn = -3;     tbl[5].mx = 0;

    @(negedge clk);
    do_reset();

    // Table: one block each with out_ready high, result appears one cycle after the last sample.
    for (int t = 0; t < 6; t++) begin
      send_block(tbl[t].xs, 1'b1);
      chk("tbl.out_valid", int'(bus.out_valid), 1);
      chk("tbl.sum",       int'(bus.sum),       tbl[t].sum);
      chk("tbl.mean",      int'(bus.mean),      tbl[t].mean);
      chk("tbl.min",       int'(bus.min),       tbl[t].mn);
      chk("tbl.max",       int'(bus.max),       tbl[t].mx);
      chk("tbl.overrun",   int'(bus.overrun),   0);
      cycle(1'b0, 0, 1'b1);
      chk("tbl.drain", int'(bus.out_valid), 0);
    end

    // Consume on the very cycle the next block completes: no bubble, no overrun.
    send_block(tbl[0].xs, 1'b0);
    for (int i = 0; i < N - 1; i++) cycle(1'b1, 2, 1'b0);
    cycle(1'b1, 2, 1'b1);
    chk("b2b.out_valid", int'(bus.out_valid), 1);
    chk("b2b.sum",       int'(bus.sum),       16);
    chk("b2b.overrun",   int'(bus.overrun),   0);
    cycle(1'b0, 0, 1'b1);

    // Reset after 5 samples; the partial block must not surface.
    for (int i = 0; i < 5; i++) cycle(1'b1, 9, 1'b1);
    do_reset();
    for (int i = 0; i < N; i++) cycle(1'b1, 3, 1'b1);
    chk("rstmid.out_valid", int'(bus.out_valid), 1);
    chk("rstmid.sum",  int'(bus.sum),  24);
    chk("rstmid.mean", int'(bus.mean), 3);
    chk("rstmid.min",  int'(bus.min),  3);
    chk("rstmid.max",  int'(bus.max),  3);
    cycle(1'b0, 0, 1'b1);

    // Two blocks complete while stalled: first result held, second dropped, overrun sticky.
    send_block(tbl[0].xs, 1'b0);
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 10, 1'b0);
      if (i < N - 1) chk("ovr.early", int'(bus.overrun), 0);
    end
    chk("ovr.flag",  int'(bus.overrun),   1);
    chk("ovr.valid", int'(bus.out_valid), 1);
    chk("ovr.sum",   int'(bus.sum),       36);
    chk("ovr.max",   int'(bus.max),       8);
    cycle(1'b0, 0, 1'b1);
    chk("ovr.drain",  int'(bus.out_valid), 0);
    chk("ovr.sticky", int'(bus.overrun),   1);

    // Randomized traffic with gaps, stalls and extreme values.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int x;
      case ($urandom_range(9))
        0:       x = 32767;
        1:       x = -32768;
        default: x = int'($urandom_range(65535)) - 32768;
      endcase
      cycle(($urandom_range(3) != 0), x, ($urandom_range(9) < 7));
      if (n == 1500) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
